clock_domain_export_fifo: RTL and testbench
===========================================

# clock_domain_export_fifo

Source-side half of a clock domain crossing. It queues up to DEPTH words from the local clock domain and drains them one at a time across a handshake to the destination clock domain. Compared with the single-word exporter it adds a FIFO, a configurable synchronizer depth, and a selectable four-phase or two-phase (toggle) protocol. It sits in the source clock domain. The matching importer sits in the destination domain.

## Interface

Parameters:

- SIZE, 8: data word width in bits.
- DEPTH, 4: FIFO entries. Must be a power of two, at least 2.
- SYNC_STAGES, 2: flip-flops in the synchronizer on `handshake_ack`. Must be at least 2.
- TOGGLE, 0: protocol select. 0 = four-phase valid/ack. 1 = two-phase, where each edge of valid or ack is one event.

Ports (one clock; reset is synchronous and active-high):

- clk  in  1  source-domain clock.
- rst  in  1  synchronous, active-high reset.
- data  in  SIZE  word to queue.
- stb  in  1  one-cycle write request for `data`.
- busy  out  1  FIFO full; a `stb` in this state is dropped.
- level  out  $clog2(DEPTH)+1  number of words queued, excluding the word in flight.
- overflow  out  1  one-cycle pulse when `stb` arrives while `busy` is high.
- sent  out  1  one-cycle pulse when the destination acknowledges the in-flight word.
- handshake_data  out  SIZE  word in flight; registered.
- handshake_valid  out  1  registered request to the other domain.
- handshake_ack  in  1  asynchronous acknowledge from the other domain.

## Operation

FIFO:
- Write when `stb && !busy`: the entry at the write pointer is written and the write pointer advances.
- Pop: when the launcher takes the head entry, the read pointer advances.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `level` is a separate counter.
- Push and pop in the same cycle leave `level` unchanged.
- `busy` = (`level` == DEPTH). Because of this, push-at-full plus pop in the same cycle is never accepted: the `stb` is dropped and `overflow` pulses.

Synchronizer:
- `handshake_ack` passes through SYNC_STAGES flops. The last stage is `ack_s`.
- The FSM reads only `ack_s`.

Launcher FSM, states IDLE, WAIT_ACK, WAIT_RELEASE:
- IDLE, when `level` != 0:
  - `handshake_data` <= FIFO head, and the FIFO pops.
  - `handshake_valid` <= 1 if TOGGLE=0, or `handshake_valid` <= ~`handshake_valid` if TOGGLE=1.
  - Next state: WAIT_ACK.
- WAIT_ACK, TOGGLE=0: when `ack_s` == 1, set `handshake_valid` <= 0 and pulse `sent`, then go to WAIT_RELEASE.
- WAIT_RELEASE (TOGGLE=0 only): when `ack_s` == 0, go to IDLE.
- WAIT_ACK, TOGGLE=1: when `ack_s` == `handshake_valid`, pulse `sent` and go to IDLE. WAIT_RELEASE is unused.
- `handshake_data` changes only in IDLE on launch, so it is stable for the whole time the request is outstanding.
- `handshake_data` and `handshake_valid` update on the same edge. Data is not synchronized; the importer's synchronized valid arrives after it.

Reset:
- Clears both pointers, `level`, the synchronizer flops, `handshake_valid`, `handshake_data`, `sent` and `overflow`. State goes to IDLE.
- Reset mid-transfer discards the in-flight word and all queued words. `handshake_valid` is 0 after the reset edge.
- With TOGGLE=1, both domains must be reset together. Otherwise a 1→0 reset of valid is seen as an event.

## Timing

Reset values: `busy` 0, `level` 0, `overflow` 0, `sent` 0, `handshake_valid` 0, `handshake_data` 0.

- Latency, empty FIFO in IDLE: `stb` sampled at edge E0 gives `level` = 1 after E0. The launch happens at E1, where `handshake_valid` rises, `handshake_data` loads and `level` returns to 0.
- Ack to `sent`: `handshake_ack` must be stable for SYNC_STAGES edges before `ack_s` reflects it. `sent` is high for the one cycle after the edge on which the FSM sees `ack_s`.
- Back-to-back, TOGGLE=0: the next launch is no earlier than 1 edge after `ack_s` returns to 0.
- Back-to-back, TOGGLE=1: the next launch is on the edge after `sent`.
- `level` and `busy` are registered and reflect all pushes and pops from the previous edge.
- `overflow` is registered and is high for the one cycle after the edge on which the dropped `stb` was sampled.

## Test plan

1. Single word, TOGGLE=0, SIZE=8, DEPTH=4, SYNC_STAGES=2: `stb` with 0xA5; the bench acks 3 cycles after valid rises and releases 3 cycles after valid falls.
   - `handshake_valid` rises 1 edge after `stb`, with `handshake_data` = 0xA5.
   - `sent` pulses once, and `level` returns to 0.
2. Fill and overflow, no acks: `stb` for 6 consecutive cycles with values 1..6.
   - The first word launches. `level` peaks at 4 and `busy` = 1.
   - The word 6 `stb` is dropped with `overflow` = 1; the word 1 launch frees a slot, so word 5 is accepted.
   - After acking, the destination receives 1,2,3,4,5 in order.
3. Wrap-around: push and drain 10 words through DEPTH=4 with random ack delays.
   - Output order equals input order.
   - `sent` count is 10.
4. TOGGLE=1: send 0x11, 0x22, 0x33; the bench mirrors `handshake_valid` onto `handshake_ack` after 4 cycles.
   - `handshake_valid` toggles 0→1→0→1, with one `sent` pulse per word and data in order.
5. Reset mid-operation: with 3 words queued and one in flight, assert `rst` for 1 cycle.
   - After the reset edge, `level` = 0, `handshake_valid` = 0, no `sent` pulse, and the FSM is in IDLE.
   - A new `stb` launches normally.
6. Simultaneous push and pop: `stb` on the launch cycle with `level` = 1.
   - `level` stays 1 and no word is lost or duplicated.

Source files
------------

// File: rtl/clock_domain_export_fifo.sv
// Source-side CDC exporter: queues words in a small FIFO and launches them one at a time
// over a four-phase or two-phase (toggle) valid/ack handshake to the destination domain.
module clock_domain_export_fifo #(
   parameter int unsigned SIZE        = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TOGGLE      = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SIZE-1:0]        data,
   input  logic                   stb,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   sent,
   output logic [SIZE-1:0]        handshake_data,
   output logic                   handshake_valid,
   input  logic                   handshake_ack
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LvlW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StWaitAck, StWaitRelease} state_e;

   logic [SIZE-1:0]        r_mem [DEPTH];
   logic [PtrW-1:0]        r_wr_ptr;
   logic [PtrW-1:0]        r_rd_ptr;
   logic [LvlW-1:0]        r_level;
   logic                   r_overflow;
   logic [SYNC_STAGES-1:0] r_sync;
   state_e                 r_state;
   logic                   r_valid;
   logic [SIZE-1:0]        r_data;
   logic                   r_sent;

   logic                   w_full;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_ack_s;
   state_e                 w_state_next;
   logic                   w_valid_d;
   logic [SIZE-1:0]        w_data_d;
   logic                   w_sent_d;

   // Full is decided on the registered level only, so a push at full is dropped even when
   // the launcher pops on the same edge.
   assign w_full = (r_level == LvlW'(DEPTH));
   assign w_push = stb && !w_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PtrW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LvlW'(1);
            2'b01:   r_level <= r_level - LvlW'(1);
            default: r_level <= r_level;
         endcase
         r_overflow <= stb && w_full;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], handshake_ack};
      end
   end

   assign w_ack_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (r_level != '0) begin
               w_state_next = StWaitAck;
            end
         end
         StWaitAck: begin
            if (TOGGLE != 0) begin
               // Two-phase: the ack catching up with valid is the completion event.
               if (w_ack_s == r_valid) begin
                  w_state_next = StIdle;
               end
            end else if (w_ack_s) begin
               w_state_next = StWaitRelease;
            end
         end
         StWaitRelease: begin
            if (!w_ack_s) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      w_pop     = 1'b0;
      w_valid_d = r_valid;
      w_data_d  = r_data;
      w_sent_d  = 1'b0;
      case (r_state)
         StIdle: begin
            if (r_level != '0) begin
               w_pop     = 1'b1;
               w_data_d  = r_mem[r_rd_ptr];
               w_valid_d = (TOGGLE != 0) ? ~r_valid : 1'b1;
            end
         end
         StWaitAck: begin
            if (TOGGLE != 0) begin
               if (w_ack_s == r_valid) begin
                  w_sent_d = 1'b1;
               end
            end else if (w_ack_s) begin
               w_valid_d = 1'b0;
               w_sent_d  = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sent  <= 1'b0;
      end else begin
         r_valid <= w_valid_d;
         r_data  <= w_data_d;
         r_sent  <= w_sent_d;
      end
   end

   assign busy            = w_full;
   assign level           = r_level;
   assign overflow        = r_overflow;
   assign sent            = r_sent;
   assign handshake_data  = r_data;
   assign handshake_valid = r_valid;

endmodule

// File: tb/tb_clock_domain_export_fifo.sv
// Bench for clock_domain_export_fifo: a four-phase and a two-phase instance, each checked
// cycle by cycle against a queue-based reference model, plus a destination-side responder.
module tb_clock_domain_export_fifo;

   localparam int SIZE  = 8;
   localparam int DEPTH = 4;
   localparam int SS    = 2;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst   [2];
   logic            stb   [2];
   logic [SIZE-1:0] din   [2];
   logic            ack   [2];
   logic            busy  [2];
   logic [LW-1:0]   level [2];
   logic            ovf   [2];
   logic            sent  [2];
   logic [SIZE-1:0] hd    [2];
   logic            hv    [2];

   clock_domain_export_fifo #(
      .SIZE(SIZE), .DEPTH(DEPTH), .SYNC_STAGES(SS), .TOGGLE(0)
   ) u_dut_4ph (
      .clk(clk), .rst(rst[0]), .data(din[0]), .stb(stb[0]), .busy(busy[0]),
      .level(level[0]), .overflow(ovf[0]), .sent(sent[0]), .handshake_data(hd[0]),
      .handshake_valid(hv[0]), .handshake_ack(ack[0])
   );

   clock_domain_export_fifo #(
      .SIZE(SIZE), .DEPTH(DEPTH), .SYNC_STAGES(SS), .TOGGLE(1)
   ) u_dut_2ph (
      .clk(clk), .rst(rst[1]), .data(din[1]), .stb(stb[1]), .busy(busy[1]),
      .level(level[1]), .overflow(ovf[1]), .sent(sent[1]), .handshake_data(hd[1]),
      .handshake_valid(hv[1]), .handshake_ack(ack[1])
   );

   // Reference model: queued words, word in flight, and a plain delay line for the ack.
   logic [SIZE-1:0] mq0[$];
   logic [SIZE-1:0] mq1[$];
   logic            m_valid [2];
   logic [SIZE-1:0] m_data  [2];
   logic            m_sent  [2];
   logic            m_ovf   [2];
   int              m_phase [2];
   logic [SS-1:0]   m_sync  [2];

   bit              r_en    [2];
   int              r_cnt   [2];
   int              dmin;
   int              dmax;
   logic [SIZE-1:0] rcv0[$];
   logic [SIZE-1:0] rcv1[$];
   logic [SIZE-1:0] expq[$];
   int              sent_cnt [2];
   int              tog_cnt  [2];
   logic            prev_hv  [2];
   int              n_checks;
   int              n_errors;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int k);
      if (k == 0) return mq0.size();
      return mq1.size();
   endfunction

   task automatic model_edge(input int k);
      int   sz;
      logic ack_s;
      bit   two_phase;
      sz        = qsize(k);
      ack_s     = m_sync[k][SS-1];
      two_phase = (k == 1);
      if (rst[k]) begin
         if (k == 0) mq0.delete(); else mq1.delete();
         m_valid[k] = 1'b0;
         m_data[k]  = '0;
         m_sent[k]  = 1'b0;
         m_ovf[k]   = 1'b0;
         m_phase[k] = 0;
         m_sync[k]  = '0;
         return;
      end
      m_sent[k] = 1'b0;
      m_ovf[k]  = stb[k] && (sz == DEPTH);
      case (m_phase[k])
         0: if (sz > 0) begin
            if (k == 0) m_data[k] = mq0.pop_front(); else m_data[k] = mq1.pop_front();
            m_valid[k] = two_phase ? ~m_valid[k] : 1'b1;
            m_phase[k] = 1;
         end
         1: if (two_phase) begin
            if (ack_s == m_valid[k]) begin
               m_sent[k]  = 1'b1;
               m_phase[k] = 0;
            end
         end else if (ack_s) begin
            m_valid[k] = 1'b0;
            m_sent[k]  = 1'b1;
            m_phase[k] = 2;
         end
         default: if (!ack_s) m_phase[k] = 0;
      endcase
      if (stb[k] && sz < DEPTH) begin
         if (k == 0) mq0.push_back(din[k]); else mq1.push_back(din[k]);
      end
      m_sync[k] = {m_sync[k][SS-2:0], ack[k]};
   endtask

   // Destination emulation: follows valid onto ack after a delay, recording each word taken.
   task automatic respond(input int k);
      if (rst[k]) begin
         ack[k]   = 1'b0;
         r_cnt[k] = 0;
         return;
      end
      if (!r_en[k] || ack[k] == hv[k]) begin
         r_cnt[k] = 0;
         return;
      end
      if (r_cnt[k] == 0) r_cnt[k] = (k == 1) ? 4 : int'($urandom_range(dmax, dmin));
      r_cnt[k]--;
      if (r_cnt[k] == 0) begin
         ack[k] = hv[k];
         if (k == 1) rcv1.push_back(hd[1]);
         else if (hv[0]) rcv0.push_back(hd[0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("level%0d", k), 32'(level[k]), 32'(qsize(k)));
         chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(qsize(k) == DEPTH));
         chk($sformatf("overflow%0d", k), 32'(ovf[k]), 32'(m_ovf[k]));
         chk($sformatf("sent%0d", k), 32'(sent[k]), 32'(m_sent[k]));
         chk($sformatf("valid%0d", k), 32'(hv[k]), 32'(m_valid[k]));
         chk($sformatf("data%0d", k), 32'(hd[k]), 32'(m_data[k]));
         if (sent[k]) sent_cnt[k]++;
         if (hv[k] !== prev_hv[k]) tog_cnt[k]++;
         prev_hv[k] = hv[k];
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         respond(k);
         stb[k] = 1'b0;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      dmin     = 1;
      dmax     = 5;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; stb[k] = 1'b0; din[k] = '0; ack[k] = 1'b0;
         r_en[k] = 1'b1; r_cnt[k] = 0; sent_cnt[k] = 0; tog_cnt[k] = 0; prev_hv[k] = 1'b0;
         m_valid[k] = 1'b0; m_data[k] = '0; m_sent[k] = 1'b0; m_ovf[k] = 1'b0;
         m_phase[k] = 0; m_sync[k] = '0;
      end
      @(negedge clk);
      step();
      step();
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      step();
      chk("rst_level", 32'(level[0]), 0);
      chk("rst_busy", 32'(busy[0]), 0);
      chk("rst_valid", 32'(hv[0]), 0);
      chk("rst_data", 32'(hd[0]), 0);

      // Single word, four-phase.
      dmin = 3; dmax = 3; rcv0.delete(); sent_cnt[0] = 0;
      din[0] = 8'hA5; stb[0] = 1'b1; step();
      chk("t1_level_after_stb", 32'(level[0]), 1);
      chk("t1_valid_before_launch", 32'(hv[0]), 0);
      step();
      chk("t1_valid_rise", 32'(hv[0]), 1);
      chk("t1_launch_data", 32'(hd[0]), 32'h A5);
      chk("t1_level_after_launch", 32'(level[0]), 0);
      repeat (30) step();
      chk("t1_sent_count", 32'(sent_cnt[0]), 1);
      chk("t1_rcv_count", 32'(rcv0.size()), 1);
      if (rcv0.size() > 0) chk("t1_rcv_data", 32'(rcv0[0]), 32'h A5);

      // Fill and overflow with the destination stalled.
      r_en[0] = 1'b0; rcv0.delete(); dmin = 1; dmax = 5;
      for (int i = 1; i <= 6; i++) begin
         din[0] = SIZE'(i); stb[0] = 1'b1; step();
         if (i == 5) begin
            chk("t2_busy_full", 32'(busy[0]), 1);
            chk("t2_level_peak", 32'(level[0]), 4);
         end
         if (i == 6) chk("t2_overflow", 32'(ovf[0]), 1);
      end
      chk("t2_inflight", 32'(hd[0]), 1);
      r_en[0] = 1'b1;
      for (int n = 0; n < 400 && rcv0.size() < 5; n++) step();
      repeat (20) step();
      chk("t2_rcv_count", 32'(rcv0.size()), 5);
      for (int i = 0; i < 5; i++)
         if (i < rcv0.size()) chk($sformatf("t2_rcv%0d", i), 32'(rcv0[i]), 32'(i + 1));

      // Wrap-around with random gaps and random ack delays.
      rcv0.delete(); expq.delete(); sent_cnt[0] = 0;
      for (int n = 0; n < 400 && expq.size() < 10; n++) begin
         if (mq0.size() < DEPTH && $urandom_range(1, 0) == 1) begin
            din[0] = SIZE'($urandom);
            stb[0] = 1'b1;
            expq.push_back(din[0]);
         end
         step();
      end
      for (int n = 0; n < 600 && rcv0.size() < 10; n++) step();
      repeat (20) step();
      chk("t3_rcv_count", 32'(rcv0.size()), 10);
      chk("t3_sent_count", 32'(sent_cnt[0]), 10);
      for (int i = 0; i < 10; i++)
         if (i < rcv0.size() && i < expq.size())
            chk($sformatf("t3_order%0d", i), 32'(rcv0[i]), 32'(expq[i]));

      // Two-phase instance.
      rcv1.delete(); sent_cnt[1] = 0; tog_cnt[1] = 0;
      din[1] = 8'h11; stb[1] = 1'b1; step();
      din[1] = 8'h22; stb[1] = 1'b1; step();
      din[1] = 8'h33; stb[1] = 1'b1; step();
      for (int n = 0; n < 200 && rcv1.size() < 3; n++) step();
      repeat (20) step();
      chk("t4_rcv_count", 32'(rcv1.size()), 3);
      chk("t4_sent_count", 32'(sent_cnt[1]), 3);
      chk("t4_toggles", 32'(tog_cnt[1]), 3);
      chk("t4_valid_final", 32'(hv[1]), 1);
      if (rcv1.size() > 0) chk("t4_rcv0", 32'(rcv1[0]), 32'h11);
      if (rcv1.size() > 1) chk("t4_rcv1", 32'(rcv1[1]), 32'h22);
      if (rcv1.size() > 2) chk("t4_rcv2", 32'(rcv1[2]), 32'h33);

      // Reset mid-transfer: one word in flight, three queued.
      r_en[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         din[0] = SIZE'(8'h40 + i); stb[0] = 1'b1; step();
      end
      chk("t5_level_pre", 32'(level[0]), 3);
      chk("t5_valid_pre", 32'(hv[0]), 1);
      chk("t5_data_pre", 32'(hd[0]), 32'h40);
      rst[0] = 1'b1; step(); rst[0] = 1'b0;
      chk("t5_level_post", 32'(level[0]), 0);
      chk("t5_valid_post", 32'(hv[0]), 0);
      chk("t5_sent_post", 32'(sent[0]), 0);
      sent_cnt[0] = 0;
      repeat (5) step();
      chk("t5_no_sent", 32'(sent_cnt[0]), 0);
      r_en[0] = 1'b1; rcv0.delete();
      din[0] = 8'h5A; stb[0] = 1'b1; step();
      step();
      chk("t5_relaunch_valid", 32'(hv[0]), 1);
      chk("t5_relaunch_data", 32'(hd[0]), 32'h5A);
      for (int n = 0; n < 200 && rcv0.size() < 1; n++) step();
      repeat (20) step();
      chk("t5_rcv_count", 32'(rcv0.size()), 1);
      if (rcv0.size() > 0) chk("t5_rcv_data", 32'(rcv0[0]), 32'h5A);

      // Push on the launch cycle.
      r_en[0] = 1'b0; rcv0.delete();
      din[0] = 8'hC1; stb[0] = 1'b1; step();
      chk("t6_level_first", 32'(level[0]), 1);
      din[0] = 8'hC2; stb[0] = 1'b1; step();
      chk("t6_level_same", 32'(level[0]), 1);
      chk("t6_launch_data", 32'(hd[0]), 32'hC1);
      r_en[0] = 1'b1;
      for (int n = 0; n < 300 && rcv0.size() < 2; n++) step();
      repeat (20) step();
      chk("t6_rcv_count", 32'(rcv0.size()), 2);
      if (rcv0.size() > 0) chk("t6_rcv0", 32'(rcv0[0]), 32'hC1);
      if (rcv0.size() > 1) chk("t6_rcv1", 32'(rcv0[1]), 32'hC2);
      chk("t6_level_end", 32'(level[0]), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
